stats_dma_latency_mc: RTL and testbench
=======================================

// Module: stats_dma_latency_mc
// PURPOSE
//  Multi-channel DMA latency collector. Timestamps each {channel,tag} start, and on finish
//  emits a per-operation record (len, status, latency, error flags). Keeps per-channel
//  latency statistics (count, sum, min, max) readable via a 1-cycle read port. Sits beside
//  the DMA engines' descriptor/completion paths in the benchmark stats subsystem.
// PARAMETERS
//  CH_COUNT      4   number of DMA channels (>=1)
//  CH_WIDTH      $clog2(CH_COUNT) (min 1)  channel index width, derived
//  TAG_WIDTH     8   tag width per channel; table depth = CH_COUNT*2**TAG_WIDTH
//  LEN_WIDTH     16  length field width
//  STATUS_WIDTH  4   completion status width
//  COUNT_WIDTH   16  timestamp/latency width
//  SUM_WIDTH     32  per-channel latency sum width (>= COUNT_WIDTH)
//  EVT_WIDTH     32  per-channel event counter width
// PORTS
//  clk               in   1             clock
//  rst_n             in   1             reset; synchronous, active-low
//  in_start_ch       in   CH_WIDTH      start channel
//  in_start_tag      in   TAG_WIDTH     start tag
//  in_start_len      in   LEN_WIDTH     operation length
//  in_start_valid    in   1             start strobe
//  in_finish_ch      in   CH_WIDTH      finish channel
//  in_finish_tag     in   TAG_WIDTH     finish tag
//  in_finish_status  in   STATUS_WIDTH  completion status
//  in_finish_valid   in   1             finish strobe
//  out_ch/out_tag    out  CH_WIDTH/TAG_WIDTH  record channel/tag
//  out_len           out  LEN_WIDTH     length captured at start (0 if orphan)
//  out_status        out  STATUS_WIDTH  finish status
//  out_latency       out  COUNT_WIDTH   finish time - start time (0 if orphan)
//  out_orphan        out  1             finish on a tag not in flight
//  out_valid         out  1             record strobe (no backpressure)
//  err_dup_start     out  1             pulse: start on a tag already in flight
//  stat_clear        in   CH_COUNT      per-channel statistics clear
//  stat_rd_ch        in   CH_WIDTH      statistics read channel
//  stat_rd_en        in   1             statistics read strobe
//  stat_rd_count     out  EVT_WIDTH     non-orphan finishes (saturating)
//  stat_rd_sum       out  SUM_WIDTH     latency sum (saturating)
//  stat_rd_min/max   out  COUNT_WIDTH   min/max latency
//  stat_rd_valid     out  1             read data strobe
// BEHAVIOUR
//  - Free-running timestamp counter, +1 per cycle, wraps mod 2**COUNT_WIDTH; 0 after reset.
//  - Start: write {len, timestamp} at {ch,tag}; set inflight bit. If already set, pulse
//    err_dup_start next cycle; entry is overwritten (newest start wins).
//  - Finish: record registered, out_valid 1 cycle after in_finish_valid. latency =
//    (ts - stored_ts) mod 2**COUNT_WIDTH. Clear inflight. If not in flight: out_orphan=1,
//    len=latency=0, stats untouched.
//  - Same-cycle start+finish, same {ch,tag}: finish uses OLD entry (read-before-write);
//    inflight ends 1 with new entry. Different {ch,tag}: fully independent.
//  - Stats update 1 cycle after finish (pipelined off the record): count+1, sum+=lat, both
//    saturate at all-ones; min=min(min,lat), max=max(max,lat).
//  - stat_clear[c] same cycle as an update to c: clear first, then apply sample
//    (count=1, sum=min=max=lat). Cleared values: count=0, sum=0, min=all-ones, max=0.
//  - Read: stat_rd_* valid 1 cycle after stat_rd_en, reflecting state incl. updates
//    committed in the cycle of stat_rd_en; otherwise outputs hold 0, stat_rd_valid=0.
//  - Reset (rst_n=0, any time): all outputs 0, timestamp 0, inflight all 0, stats cleared;
//    in-progress records/updates dropped. Len/timestamp RAM contents not reset.
//  - Out-of-range ch (>= CH_COUNT): input ignored, no record, no error.
// STRUCTURE
//  - Package stats_dma_pkg: stats record field widths, MIN_INIT constant (all-ones).
//  - Sub-module stats_lat_accum: one channel's count/sum/min/max with clear and saturation;
//    instantiated CH_COUNT times. Tag table (distributed RAM) + inflight flops in top.
// TESTING
//  - Start ch1 tag5 len 64 at ts 10, finish at ts 42 -> out_valid, ch1 tag5 len 64 lat 32.
//  - Finish ch0 tag3 never started -> out_orphan=1, len 0, lat 0; ch0 count stays 0.
//  - Start ch2 tag7 twice -> err_dup_start pulse; finish gives latency from 2nd start.
//  - Start ts 0xFFF0, finish ts 0x0010 (COUNT_WIDTH 16) -> latency 0x0020.
//  - Lat 5,9,3 on ch3 then read -> count 3, sum 17, min 3, max 9; clear -> 0,0,FFFF,0.
//  - Same-cycle start+finish on ch0 tag1 (started earlier) -> old latency out, tag in flight;
//    rst_n low mid-operation -> all outputs 0, later finish reports orphan.

Source files
------------

// File: rtl/stats_dma_pkg.sv
// Shared default widths and constants for the DMA latency statistics block.
// Defaults here size the top level when it is instantiated without overrides.
package stats_dma_pkg;

  localparam int DEF_CH_COUNT     = 4;
  localparam int DEF_TAG_WIDTH    = 8;
  localparam int DEF_LEN_WIDTH    = 16;
  localparam int DEF_STATUS_WIDTH = 4;
  localparam int DEF_COUNT_WIDTH  = 16;
  localparam int DEF_SUM_WIDTH    = 32;
  localparam int DEF_EVT_WIDTH    = 32;

  // Value a cleared minimum takes, so the first sample always replaces it.
  localparam logic [DEF_COUNT_WIDTH-1:0] MIN_INIT = '1;

  typedef struct packed {
    logic [DEF_EVT_WIDTH-1:0]   count;
    logic [DEF_SUM_WIDTH-1:0]   sum;
    logic [DEF_COUNT_WIDTH-1:0] min;
    logic [DEF_COUNT_WIDTH-1:0] max;
  } stats_rec_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stats_lat_accum.sv
// One channel's latency statistics: saturating count and sum, running min and max.
// Exposes next-state values so a read issued alongside an update sees the update.
module stats_lat_accum
  import stats_dma_pkg::*;
#(
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int SUM_WIDTH   = DEF_SUM_WIDTH,
  parameter int EVT_WIDTH   = DEF_EVT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   upd_i,
  input  logic [COUNT_WIDTH-1:0] lat_i,
  output logic [EVT_WIDTH-1:0]   nxt_count_o,
  output logic [SUM_WIDTH-1:0]   nxt_sum_o,
  output logic [COUNT_WIDTH-1:0] nxt_min_o,
  output logic [COUNT_WIDTH-1:0] nxt_max_o
);

  logic [EVT_WIDTH-1:0]   count_q, count_d;
  logic [SUM_WIDTH-1:0]   sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] min_q, min_d;
  logic [COUNT_WIDTH-1:0] max_q, max_d;

  function automatic logic [EVT_WIDTH-1:0] sat_inc(input logic [EVT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0] a,
                                                   input logic [COUNT_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + {{(SUM_WIDTH + 1 - COUNT_WIDTH){1'b0}}, b};
    return s[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : s[SUM_WIDTH-1:0];
  endfunction

  // Clear is applied before the sample so a simultaneous clear+update keeps the sample.
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clear_i) begin
      count_d = '0;
      sum_d   = '0;
      min_d   = '1;
      max_d   = '0;
    end
    if (upd_i) begin
      count_d = sat_inc(count_d);
      sum_d   = sat_add(sum_d, lat_i);
      if (lat_i < min_d) min_d = lat_i;
      if (lat_i > max_d) max_d = lat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

  assign nxt_count_o = count_d;
  assign nxt_sum_o   = sum_d;
  assign nxt_min_o   = min_d;
  assign nxt_max_o   = max_d;

endmodule

// File: rtl/stats_dma_latency_mc.sv
// Multi-channel DMA latency collector: timestamps starts per {channel,tag}, emits a
// record per finish and keeps per-channel latency statistics behind a 1-cycle read port.
module stats_dma_latency_mc
  import stats_dma_pkg::*;
#(
  parameter int CH_COUNT     = DEF_CH_COUNT,
  parameter int CH_WIDTH     = ch_width(CH_COUNT),
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
  parameter int STATUS_WIDTH = DEF_STATUS_WIDTH,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int SUM_WIDTH    = DEF_SUM_WIDTH,
  parameter int EVT_WIDTH    = DEF_EVT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_WIDTH-1:0]     in_start_ch,
  input  logic [TAG_WIDTH-1:0]    in_start_tag,
  input  logic [LEN_WIDTH-1:0]    in_start_len,
  input  logic                    in_start_valid,
  input  logic [CH_WIDTH-1:0]     in_finish_ch,
  input  logic [TAG_WIDTH-1:0]    in_finish_tag,
  input  logic [STATUS_WIDTH-1:0] in_finish_status,
  input  logic                    in_finish_valid,
  output logic [CH_WIDTH-1:0]     out_ch,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [LEN_WIDTH-1:0]    out_len,
  output logic [STATUS_WIDTH-1:0] out_status,
  output logic [COUNT_WIDTH-1:0]  out_latency,
  output logic                    out_orphan,
  output logic                    out_valid,
  output logic                    err_dup_start,
  input  logic [CH_COUNT-1:0]     stat_clear,
  input  logic [CH_WIDTH-1:0]     stat_rd_ch,
  input  logic                    stat_rd_en,
  output logic [EVT_WIDTH-1:0]    stat_rd_count,
  output logic [SUM_WIDTH-1:0]    stat_rd_sum,
  output logic [COUNT_WIDTH-1:0]  stat_rd_min,
  output logic [COUNT_WIDTH-1:0]  stat_rd_max,
  output logic                    stat_rd_valid
);

  // Table is addressed by the {ch,tag} concatenation, so it spans the full index space.
  localparam int IDX_W = CH_WIDTH + TAG_WIDTH;
  localparam int DEPTH = 1 << IDX_W;

  function automatic logic ch_in_range(input logic [CH_WIDTH-1:0] ch);
    return int'(ch) < CH_COUNT;
  endfunction

  logic [COUNT_WIDTH-1:0] ts_q;
  logic [DEPTH-1:0]       inflight_q, inflight_d;
  logic [LEN_WIDTH-1:0]   len_mem [DEPTH];
  logic [COUNT_WIDTH-1:0] ts_mem  [DEPTH];

  logic [IDX_W-1:0]       s_idx, f_idx;
  logic                   s_ok, f_ok, f_hit, rd_ok;
  logic [COUNT_WIDTH-1:0] f_lat;

  logic [CH_WIDTH-1:0]     rec_ch_q;
  logic [TAG_WIDTH-1:0]    rec_tag_q;
  logic [LEN_WIDTH-1:0]    rec_len_q;
  logic [STATUS_WIDTH-1:0] rec_status_q;
  logic [COUNT_WIDTH-1:0]  rec_lat_q;
  logic                    rec_orphan_q, rec_vld_q, dup_q;

  logic [EVT_WIDTH-1:0]   nxt_count [CH_COUNT];
  logic [SUM_WIDTH-1:0]   nxt_sum   [CH_COUNT];
  logic [COUNT_WIDTH-1:0] nxt_min   [CH_COUNT];
  logic [COUNT_WIDTH-1:0] nxt_max   [CH_COUNT];

  logic [EVT_WIDTH-1:0]   rd_count_q;
  logic [SUM_WIDTH-1:0]   rd_sum_q;
  logic [COUNT_WIDTH-1:0] rd_min_q, rd_max_q;
  logic                   rd_vld_q;

  assign s_idx = {in_start_ch, in_start_tag};
  assign f_idx = {in_finish_ch, in_finish_tag};
  assign s_ok  = in_start_valid && ch_in_range(in_start_ch);
  assign f_ok  = in_finish_valid && ch_in_range(in_finish_ch);
  assign rd_ok = stat_rd_en && ch_in_range(stat_rd_ch);

  // Asynchronous table read gives the finish the pre-write entry on a same-cycle start.
  assign f_hit = inflight_q[f_idx];
  assign f_lat = ts_q - ts_mem[f_idx];

  always_comb begin
    inflight_d = inflight_q;
    if (f_ok) inflight_d[f_idx] = 1'b0;
    if (s_ok) inflight_d[s_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= '0;
      inflight_q <= '0;
      dup_q      <= 1'b0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      inflight_q <= inflight_d;
      dup_q      <= s_ok && inflight_q[s_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (s_ok) begin
      len_mem[s_idx] <= in_start_len;
      ts_mem[s_idx]  <= ts_q;
    end
  end

  // Record stage: one cycle after the finish strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_vld_q    <= 1'b0;
      rec_ch_q     <= '0;
      rec_tag_q    <= '0;
      rec_len_q    <= '0;
      rec_status_q <= '0;
      rec_lat_q    <= '0;
      rec_orphan_q <= 1'b0;
    end else begin
      rec_vld_q <= f_ok;
      if (f_ok) begin
        rec_ch_q     <= in_finish_ch;
        rec_tag_q    <= in_finish_tag;
        rec_status_q <= in_finish_status;
        rec_len_q    <= f_hit ? len_mem[f_idx] : '0;
        rec_lat_q    <= f_hit ? f_lat : '0;
        rec_orphan_q <= !f_hit;
      end
    end
  end

  // Statistics stage: fed from the registered record, committed one cycle later.
  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    logic upd;
    assign upd = rec_vld_q && !rec_orphan_q && (rec_ch_q == CH_WIDTH'(c));

    stats_lat_accum #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .SUM_WIDTH   (SUM_WIDTH),
      .EVT_WIDTH   (EVT_WIDTH)
    ) u_accum (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (stat_clear[c]),
      .upd_i       (upd),
      .lat_i       (rec_lat_q),
      .nxt_count_o (nxt_count[c]),
      .nxt_sum_o   (nxt_sum[c]),
      .nxt_min_o   (nxt_min[c]),
      .nxt_max_o   (nxt_max[c])
    );
  end

  // Read stage: samples next-state so same-cycle commits are visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q   <= 1'b0;
      rd_count_q <= '0;
      rd_sum_q   <= '0;
      rd_min_q   <= '0;
      rd_max_q   <= '0;
    end else begin
      rd_vld_q <= rd_ok;
      if (rd_ok) begin
        rd_count_q <= nxt_count[stat_rd_ch];
        rd_sum_q   <= nxt_sum[stat_rd_ch];
        rd_min_q   <= nxt_min[stat_rd_ch];
        rd_max_q   <= nxt_max[stat_rd_ch];
      end else begin
        rd_count_q <= '0;
        rd_sum_q   <= '0;
        rd_min_q   <= '0;
        rd_max_q   <= '0;
      end
    end
  end

  assign out_ch        = rec_ch_q;
  assign out_tag       = rec_tag_q;
  assign out_len       = rec_len_q;
  assign out_status    = rec_status_q;
  assign out_latency   = rec_lat_q;
  assign out_orphan    = rec_orphan_q;
  assign out_valid     = rec_vld_q;
  assign err_dup_start = dup_q;
  assign stat_rd_count = rd_count_q;
  assign stat_rd_sum   = rd_sum_q;
  assign stat_rd_min   = rd_min_q;
  assign stat_rd_max   = rd_max_q;
  assign stat_rd_valid = rd_vld_q;

endmodule

// File: tb/tb_stats_dma_latency_mc.sv
// Directed bench for stats_dma_latency_mc with default parameters (4 ch, 8-bit tags).
// tb_ts counts cycles since reset release so start/finish times can be placed exactly.
module tb_stats_dma_latency_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_start_ch = '0;
  logic [7:0]  in_start_tag = '0;
  logic [15:0] in_start_len = '0;
  logic        in_start_valid = 1'b0;
  logic [1:0]  in_finish_ch = '0;
  logic [7:0]  in_finish_tag = '0;
  logic [3:0]  in_finish_status = '0;
  logic        in_finish_valid = 1'b0;
  logic [1:0]  out_ch;
  logic [7:0]  out_tag;
  logic [15:0] out_len;
  logic [3:0]  out_status;
  logic [15:0] out_latency;
  logic        out_orphan, out_valid, err_dup_start;
  logic [3:0]  stat_clear = '0;
  logic [1:0]  stat_rd_ch = '0;
  logic        stat_rd_en = 1'b0;
  logic [31:0] stat_rd_count, stat_rd_sum;
  logic [15:0] stat_rd_min, stat_rd_max;
  logic        stat_rd_valid;

  int checks = 0;
  int errors = 0;
  logic [15:0] tb_ts = '0;

  stats_dma_latency_mc dut (
    .clk(clk), .rst_n(rst_n),
    .in_start_ch(in_start_ch), .in_start_tag(in_start_tag), .in_start_len(in_start_len),
    .in_start_valid(in_start_valid),
    .in_finish_ch(in_finish_ch), .in_finish_tag(in_finish_tag),
    .in_finish_status(in_finish_status), .in_finish_valid(in_finish_valid),
    .out_ch(out_ch), .out_tag(out_tag), .out_len(out_len), .out_status(out_status),
    .out_latency(out_latency), .out_orphan(out_orphan), .out_valid(out_valid),
    .err_dup_start(err_dup_start),
    .stat_clear(stat_clear), .stat_rd_ch(stat_rd_ch), .stat_rd_en(stat_rd_en),
    .stat_rd_count(stat_rd_count), .stat_rd_sum(stat_rd_sum),
    .stat_rd_min(stat_rd_min), .stat_rd_max(stat_rd_max), .stat_rd_valid(stat_rd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_ts <= rst_n ? tb_ts + 16'd1 : 16'd0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ts(input logic [15:0] t, input int bound);
    int n = 0;
    while (tb_ts != t && n < bound) begin
      cyc();
      n++;
    end
    checks++;
    if (tb_ts !== t) begin errors++; $display("FAIL wait_ts: got %h want %h", tb_ts, t); end
  endtask

  task automatic do_start(input logic [1:0] ch, input logic [7:0] tag, input logic [15:0] len);
    in_start_ch = ch; in_start_tag = tag; in_start_len = len; in_start_valid = 1'b1;
    cyc();
    in_start_valid = 1'b0;
  endtask

  task automatic do_finish(input logic [1:0] ch, input logic [7:0] tag, input logic [3:0] st);
    in_finish_ch = ch; in_finish_tag = tag; in_finish_status = st; in_finish_valid = 1'b1;
    cyc();
    in_finish_valid = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] ch);
    stat_rd_ch = ch; stat_rd_en = 1'b1;
    cyc();
    stat_rd_en = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] ch, input logic [7:0] tag, input int lat);
    do_start(ch, tag, 16'd1);
    idle(lat - 1);
    do_finish(ch, tag, 4'd0);
    checks++;
    if (out_latency !== 16'(lat) || out_valid !== 1'b1) begin
      errors++; $display("FAIL op_lat: got %0d/%b want %0d/1", out_latency, out_valid, lat);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_latency !== 16'd0 || out_len !== 16'd0) begin errors++; $display("FAIL rst_data: got lat %0d len %0d want 0 0", out_latency, out_len); end
    checks++; if (err_dup_start !== 1'b0) begin errors++; $display("FAIL rst_dup: got %b want 0", err_dup_start); end
    checks++; if (stat_rd_valid !== 1'b0 || stat_rd_min !== 16'd0) begin errors++; $display("FAIL rst_rd: got vld %b min %h want 0 0", stat_rd_valid, stat_rd_min); end
    do_read(2'd0);
    checks++; if (stat_rd_valid !== 1'b1 || stat_rd_count !== 32'd0 || stat_rd_min !== 16'hFFFF || stat_rd_max !== 16'd0) begin
      errors++; $display("FAIL rst_stats: got vld %b cnt %0d min %h max %h want 1 0 ffff 0", stat_rd_valid, stat_rd_count, stat_rd_min, stat_rd_max);
    end
    cyc();
    checks++; if (stat_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_drop: got %b want 0", stat_rd_valid); end
  endtask

  task automatic test_basic();
    wait_ts(16'd10, 50);
    do_start(2'd1, 8'd5, 16'd64);
    wait_ts(16'd42, 50);
    do_finish(2'd1, 8'd5, 4'd3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_ch !== 2'd1 || out_tag !== 8'd5) begin errors++; $display("FAIL basic_id: got ch %0d tag %0d want 1 5", out_ch, out_tag); end
    checks++; if (out_len !== 16'd64) begin errors++; $display("FAIL basic_len: got %0d want 64", out_len); end
    checks++; if (out_latency !== 16'd32) begin errors++; $display("FAIL basic_lat: got %0d want 32", out_latency); end
    checks++; if (out_orphan !== 1'b0 || out_status !== 4'd3) begin errors++; $display("FAIL basic_flags: got orphan %b st %0d want 0 3", out_orphan, out_status); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", out_valid); end
    do_read(2'd1);
    checks++; if (stat_rd_count !== 32'd1 || stat_rd_sum !== 32'd32 || stat_rd_min !== 16'd32 || stat_rd_max !== 16'd32) begin
      errors++; $display("FAIL basic_stats: got %0d %0d %0d %0d want 1 32 32 32", stat_rd_count, stat_rd_sum, stat_rd_min, stat_rd_max);
    end
  endtask

  task automatic test_orphan();
    do_finish(2'd0, 8'd3, 4'd1);
    checks++; if (out_valid !== 1'b1 || out_orphan !== 1'b1) begin errors++; $display("FAIL orphan_flag: got vld %b orphan %b want 1 1", out_valid, out_orphan); end
    checks++; if (out_len !== 16'd0 || out_latency !== 16'd0) begin errors++; $display("FAIL orphan_data: got len %0d lat %0d want 0 0", out_len, out_latency); end
    do_read(2'd0);
    checks++; if (stat_rd_count !== 32'd0) begin errors++; $display("FAIL orphan_stats: got %0d want 0", stat_rd_count); end
  endtask

  task automatic test_dup();
    do_start(2'd2, 8'd7, 16'd10);
    checks++; if (err_dup_start !== 1'b0) begin errors++; $display("FAIL dup_first: got %b want 0", err_dup_start); end
    idle(2);
    do_start(2'd2, 8'd7, 16'd20);
    checks++; if (err_dup_start !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b want 1", err_dup_start); end
    idle(1);
    checks++; if (err_dup_start !== 1'b0) begin errors++; $display("FAIL dup_end: got %b want 0", err_dup_start); end
    idle(3);
    do_finish(2'd2, 8'd7, 4'd0);
    checks++; if (out_latency !== 16'd5 || out_len !== 16'd20 || out_orphan !== 1'b0) begin
      errors++; $display("FAIL dup_rec: got lat %0d len %0d orphan %b want 5 20 0", out_latency, out_len, out_orphan);
    end
  endtask

  task automatic test_stats();
    do_op(2'd3, 8'd1, 5);
    do_op(2'd3, 8'd2, 9);
    do_op(2'd3, 8'd3, 3);
    do_read(2'd3);
    checks++; if (stat_rd_count !== 32'd3 || stat_rd_sum !== 32'd17 || stat_rd_min !== 16'd3 || stat_rd_max !== 16'd9) begin
      errors++; $display("FAIL stats_acc: got %0d %0d %0d %0d want 3 17 3 9", stat_rd_count, stat_rd_sum, stat_rd_min, stat_rd_max);
    end
    stat_clear = 4'b1000;
    cyc();
    stat_clear = 4'b0000;
    do_read(2'd3);
    checks++; if (stat_rd_count !== 32'd0 || stat_rd_sum !== 32'd0 || stat_rd_min !== 16'hFFFF || stat_rd_max !== 16'd0) begin
      errors++; $display("FAIL stats_clr: got %0d %0d %h %0d want 0 0 ffff 0", stat_rd_count, stat_rd_sum, stat_rd_min, stat_rd_max);
    end
    do_op(2'd3, 8'd4, 6);
    do_op(2'd3, 8'd5, 4);
    stat_clear = 4'b1000; stat_rd_ch = 2'd3; stat_rd_en = 1'b1;
    cyc();
    stat_clear = 4'b0000; stat_rd_en = 1'b0;
    checks++; if (stat_rd_count !== 32'd1 || stat_rd_sum !== 32'd4 || stat_rd_min !== 16'd4 || stat_rd_max !== 16'd4) begin
      errors++; $display("FAIL stats_clr_upd: got %0d %0d %0d %0d want 1 4 4 4", stat_rd_count, stat_rd_sum, stat_rd_min, stat_rd_max);
    end
    do_read(2'd1);
    checks++; if (stat_rd_count !== 32'd1 || stat_rd_sum !== 32'd32) begin
      errors++; $display("FAIL stats_other_ch: got %0d %0d want 1 32", stat_rd_count, stat_rd_sum);
    end
  endtask

  task automatic test_same_cycle();
    do_start(2'd0, 8'd1, 16'd8);
    idle(5);
    in_start_ch = 2'd0; in_start_tag = 8'd1; in_start_len = 16'd99; in_start_valid = 1'b1;
    in_finish_ch = 2'd0; in_finish_tag = 8'd1; in_finish_status = 4'd2; in_finish_valid = 1'b1;
    cyc();
    in_start_valid = 1'b0; in_finish_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_orphan !== 1'b0 || out_len !== 16'd8 || out_latency !== 16'd6) begin
      errors++; $display("FAIL same_old: got vld %b orphan %b len %0d lat %0d want 1 0 8 6", out_valid, out_orphan, out_len, out_latency);
    end
    idle(2);
    do_finish(2'd0, 8'd1, 4'd0);
    checks++; if (out_orphan !== 1'b0 || out_len !== 16'd99 || out_latency !== 16'd3) begin
      errors++; $display("FAIL same_new: got orphan %b len %0d lat %0d want 0 99 3", out_orphan, out_len, out_latency);
    end
  endtask

  task automatic test_reset_mid();
    do_start(2'd1, 8'd9, 16'd7);
    do_start(2'd1, 8'd8, 16'd7);
    idle(1);
    rst_n = 1'b0;
    in_finish_ch = 2'd1; in_finish_tag = 8'd8; in_finish_valid = 1'b1;
    stat_rd_ch = 2'd1; stat_rd_en = 1'b1;
    cyc();
    in_finish_valid = 1'b0; stat_rd_en = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_len !== 16'd0 || out_latency !== 16'd0 || out_ch !== 2'd0) begin
      errors++; $display("FAIL mid_rst_rec: got vld %b len %0d lat %0d ch %0d want 0 0 0 0", out_valid, out_len, out_latency, out_ch);
    end
    checks++; if (stat_rd_valid !== 1'b0 || stat_rd_count !== 32'd0) begin
      errors++; $display("FAIL mid_rst_rd: got vld %b cnt %0d want 0 0", stat_rd_valid, stat_rd_count);
    end
    rst_n = 1'b1;
    do_read(2'd1);
    checks++; if (stat_rd_count !== 32'd0 || stat_rd_min !== 16'hFFFF) begin
      errors++; $display("FAIL mid_rst_stats: got %0d %h want 0 ffff", stat_rd_count, stat_rd_min);
    end
    do_finish(2'd1, 8'd9, 4'd0);
    checks++; if (out_valid !== 1'b1 || out_orphan !== 1'b1 || out_len !== 16'd0) begin
      errors++; $display("FAIL mid_rst_orphan: got vld %b orphan %b len %0d want 1 1 0", out_valid, out_orphan, out_len);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    wait_ts(16'hFFF0, 70000);
    do_start(2'd2, 8'd4, 16'd1);
    wait_ts(16'h0010, 100);
    do_finish(2'd2, 8'd4, 4'd0);
    checks++; if (out_latency !== 16'h0020 || out_orphan !== 1'b0) begin
      errors++; $display("FAIL wrap_lat: got %h orphan %b want 0020 0", out_latency, out_orphan);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_orphan();
    test_dup();
    test_stats();
    test_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
